// File: rtl/imm_gen_stage.sv
// RV immediate decode stage: extracts/sign-extends the immediate, classifies the format and
// buffers results in a small FIFO. Optional feature macro: IMM_ERR_CNT_EN (illegal-opcode counter).
module imm_gen_stage #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] FMT_I   = 3'd0;
    localparam logic [2:0] FMT_S   = 3'd1;
    localparam logic [2:0] FMT_B   = 3'd2;
    localparam logic [2:0] FMT_U   = 3'd3;
    localparam logic [2:0] FMT_J   = 3'd4;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    // ---------------------------------------------------------------- decode
    logic [31:0]     dec_imm32;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        dec_imm32 = '0;
        dec_fmt   = FMT_ILL;
        unique case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec_fmt   = FMT_I;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt   = FMT_J;
                dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            end
            default: begin
                dec_fmt   = FMT_ILL;
                dec_imm32 = '0;
            end
        endcase
    end

    // Bit 31 of every 32-bit immediate equals instr[31] (or 0 for illegal), so a signed cast extends correctly.
    assign dec_imm = XLEN'($signed(dec_imm32));

    // ---------------------------------------------------------------- buffer state
    logic [XLEN-1:0] mem_imm_q [FIFO_DEPTH];
    logic [XLEN-1:0] mem_imm_d [FIFO_DEPTH];
    logic [2:0]      mem_fmt_q [FIFO_DEPTH];
    logic [2:0]      mem_fmt_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic push, pop;

    // No pop-through: readiness depends only on the registered count.
    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_imm_d = mem_imm_q;
        mem_fmt_d = mem_fmt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_imm_d[wr_ptr_q] = dec_imm;
                mem_fmt_d[wr_ptr_q] = dec_fmt;
                wr_ptr_d            = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_imm_q[i] <= '0;
                mem_fmt_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_imm_q <= mem_imm_d;
            mem_fmt_q <= mem_fmt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Empty buffer presents zeros rather than stale storage.
    assign out_imm = out_valid ? mem_imm_q[rd_ptr_q] : '0;
    assign out_fmt = out_valid ? mem_fmt_q[rd_ptr_q] : '0;

    // ---------------------------------------------------------------- illegal-opcode counter
`ifdef IMM_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (push && !flush && (dec_fmt == FMT_ILL) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
